// File: rtl/tdm_demux.sv
// Serial TDM demultiplexer: hunts for frame sync, assembles CHANNELS words per frame and publishes them together.
// Optional per-slot even parity bit enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         sync_in,
    input  logic                         data_in,
    output logic [CHANNELS*WIDTH-1:0]    ch_data,
    output logic                         frame_valid,
    output logic [$clog2(CHANNELS)-1:0]  slot,
    output logic                         sync_err,
    output logic [CHANNELS-1:0]          parity_err
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT_BITS = WIDTH + 1;
`else
    localparam int SLOT_BITS = WIDTH;
`endif
    localparam int CNT_W  = $clog2(SLOT_BITS + 1);
    localparam int SLOT_W = $clog2(CHANNELS);

    typedef enum logic {HUNT, RECEIVE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [SLOT_BITS-1:0] shreg;
    logic [WIDTH-1:0]     staging [CHANNELS];
    logic                 xfer_pend;
`ifdef TDM_DEMUX_PARITY_EN
    logic [CHANNELS-1:0]  stage_par;
`endif

    logic                 unexpected;
    logic                 start;
    logic                 take;
    logic                 last_bit;
    logic                 frame_end;
    logic [CNT_W-1:0]     cur_cnt;
    logic [SLOT_W-1:0]    cur_slot;
    logic [SLOT_BITS-1:0] word;

    // A sync anywhere but the expected slot-0 MSB restarts the frame on this very bit.
    always_comb begin
        unexpected = sync_in && (state == RECEIVE) && (bit_cnt != '0 || slot != '0);
        start      = sync_in && (state == HUNT || unexpected);
        take       = (state == RECEIVE) || sync_in;
        cur_cnt    = start ? '0 : bit_cnt;
        cur_slot   = start ? '0 : slot;
        word       = SLOT_BITS'({shreg, data_in});
        last_bit   = (cur_cnt == CNT_W'(SLOT_BITS - 1));
        frame_end  = take && last_bit && (cur_slot == SLOT_W'(CHANNELS - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            bit_cnt     <= '0;
            slot        <= '0;
            shreg       <= '0;
            ch_data     <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            xfer_pend   <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) staging[k] <= '0;
`ifdef TDM_DEMUX_PARITY_EN
            stage_par   <= '0;
            parity_err  <= '0;
`endif
        end else begin
            frame_valid <= xfer_pend;
            sync_err    <= unexpected;
            xfer_pend   <= frame_end;

            // Publish stage: a completed frame is copied out one edge after its last bit.
            if (xfer_pend) begin
                for (int k = 0; k < CHANNELS; k++) ch_data[k*WIDTH +: WIDTH] <= staging[k];
`ifdef TDM_DEMUX_PARITY_EN
                parity_err <= stage_par;
`endif
            end

            if (take) begin
                state <= RECEIVE;
                shreg <= word;
                if (last_bit) begin
                    staging[cur_slot] <= word[SLOT_BITS-1 -: WIDTH];
`ifdef TDM_DEMUX_PARITY_EN
                    stage_par[cur_slot] <= ^word;
`endif
                    bit_cnt <= '0;
                    slot    <= frame_end ? '0 : cur_slot + SLOT_W'(1);
                end else begin
                    bit_cnt <= cur_cnt + CNT_W'(1);
                    slot    <= cur_slot;
                end
            end
        end
    end

`ifndef TDM_DEMUX_PARITY_EN
    assign parity_err = '0;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (CHANNELS=4, WIDTH=8); parity scenario runs when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int SB = 9;
`else
    localparam int SB = 8;
`endif
    localparam int FB = 4 * SB;

    logic        clock;
    logic        reset;
    logic        sync_in;
    logic        data_in;
    logic [31:0] ch_data;
    logic        frame_valid;
    logic [1:0]  slot;
    logic        sync_err;
    logic [3:0]  parity_err;

    tdm_demux #(.CHANNELS(4), .WIDTH(8)) dut (
        .clock(clock), .reset(reset), .sync_in(sync_in), .data_in(data_in),
        .ch_data(ch_data), .frame_valid(frame_valid), .slot(slot),
        .sync_err(sync_err), .parity_err(parity_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fv_n = 0;
    int se_n = 0;
    int se_cyc = 0;
    logic [31:0] fv_log[$];
    logic [3:0]  fvp_log[$];
    int          fv_cyc_log[$];
`ifdef TDM_DEMUX_PARITY_EN
    logic [3:0]  par_flip = 4'b0000;
`endif

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (frame_valid) begin
            fv_n++;
            fv_log.push_back(ch_data);
            fvp_log.push_back(parity_err);
            fv_cyc_log.push_back(cyc);
        end
        if (sync_err) begin
            se_n++;
            se_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic s, input logic d);
        sync_in = s;
        data_in = d;
        @(posedge clock);
        #1;
    endtask

    // Frame packed as {slot3, slot2, slot1, slot0}; each slot MSB first.
    task automatic send_frame(input logic [31:0] f, input logic sync_first);
        logic [7:0] w;
        for (int k = 0; k < 4; k++) begin
            w = f[k*8 +: 8];
            for (int b = 7; b >= 0; b--) tick(sync_first && k == 0 && b == 7, w[b]);
`ifdef TDM_DEMUX_PARITY_EN
            tick(1'b0, (^w) ^ par_flip[k]);
`endif
        end
    endtask

    typedef struct {
        logic       sync;
        logic [7:0] s0, s1, s2, s3;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];
    int   lastc[5];
    int   fv0;
    int   se0;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hFF, 8'h00, 32'h00FF3CA5};
        vecs[1] = '{1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
        vecs[2] = '{1'b1, 8'h80, 8'h7F, 8'h55, 8'hAA, 32'hAA557F80};
        vecs[3] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
        vecs[4] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};

        reset = 1'b1; sync_in = 1'b0; data_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset ch_data", ch_data, 32'h0);
        check("reset frame_valid", 32'(frame_valid), 32'h0);
        check("reset slot", 32'(slot), 32'h0);
        check("reset sync_err", 32'(sync_err), 32'h0);
        check("reset parity_err", 32'(parity_err), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) tick(1'b0, i[0]);
        check("hunt slot", 32'(slot), 32'h0);
        check("hunt no frame", 32'(fv_n), 32'h0);
        check("hunt ch_data", ch_data, 32'h0);

        for (int i = 0; i < 5; i++) begin
            send_frame({vecs[i].s3, vecs[i].s2, vecs[i].s1, vecs[i].s0}, vecs[i].sync);
            lastc[i] = cyc;
        end
        tick(1'b0, 1'b0);
        @(negedge clock); #1;
        check("table frame count", 32'(fv_n), 32'd5);
        check("table sync_err count", 32'(se_n), 32'd0);
        if (fv_n == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("vec%0d ch_data", i), fv_log[i], vecs[i].exp);
                check($sformatf("vec%0d parity_err", i), 32'(fvp_log[i]), 32'h0);
                check($sformatf("vec%0d latency", i), 32'(fv_cyc_log[i]), 32'(lastc[i] + 1));
            end
            check("back-to-back spacing", 32'(fv_cyc_log[1] - fv_cyc_log[0]), 32'(FB));
        end

        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
        check("hold ch_data", ch_data, 32'hFFFFFFFF);
        check("hold frame_valid", 32'(frame_valid), 32'h0);

        // Resync in the middle of slot 1.
        reset = 1'b1; @(posedge clock); #1; reset = 1'b0;
        tick(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b0, i[0]);
        check("resync slot before", 32'(slot), 32'd1);
        fv0 = fv_n;
        se0 = se_n;
        send_frame(32'hD4C3B2A1, 1'b1);
        tick(1'b0, 1'b0);
        @(negedge clock); #1;
        check("resync sync_err pulses", 32'(se_n - se0), 32'd1);
        check("resync frame count", 32'(fv_n - fv0), 32'd1);
        if (fv_n - fv0 == 1) begin
            check("resync latency", 32'(fv_cyc_log[fv_n-1] - se_cyc), 32'(FB));
            check("resync ch_data", fv_log[fv_n-1], 32'hD4C3B2A1);
        end

        // Reset mid-frame, then a clean frame.
        tick(1'b1, 1'b1);
        for (int i = 0; i < 19; i++) tick(1'b0, i[1]);
        #2 reset = 1'b1;
        #1;
        check("async reset ch_data", ch_data, 32'h0);
        check("async reset slot", 32'(slot), 32'h0);
        check("async reset frame_valid", 32'(frame_valid), 32'h0);
        @(posedge clock);
        #2 reset = 1'b0;
        fv0 = fv_n;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
        check("post-reset hunt slot", 32'(slot), 32'h0);
        send_frame(32'h44332211, 1'b1);
        check("post-reset ch_data before", ch_data, 32'h0);
        check("post-reset no early valid", 32'(frame_valid), 32'h0);
        tick(1'b0, 1'b0);
        check("post-reset frame_valid", 32'(frame_valid), 32'h1);
        check("post-reset ch_data", ch_data, 32'h44332211);
        check("post-reset parity_err", 32'(parity_err), 32'h0);
        @(negedge clock); #1;
        check("post-reset frame count", 32'(fv_n - fv0), 32'd1);

`ifdef TDM_DEMUX_PARITY_EN
        reset = 1'b1; @(posedge clock); #1; reset = 1'b0;
        par_flip = 4'b0100;
        send_frame(32'h8D7C6B5A, 1'b1);
        par_flip = 4'b0000;
        check("parity no early valid", 32'(frame_valid), 32'h0);
        tick(1'b0, 1'b0);
        check("parity frame_valid", 32'(frame_valid), 32'h1);
        check("parity parity_err", 32'(parity_err), 32'h4);
        check("parity ch_data", ch_data, 32'h8D7C6B5A);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter CHANNELS, default 4, number of time slots per frame (2..16).
REQ-002 Parameter WIDTH, default 8, data bits per slot (1..16).
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sync_in  input  1  frame sync; high marks the first bit of slot 0.
REQ-006 data_in  input  1  serial TDM stream, one bit per clock, MSB of each slot first.
REQ-007 ch_data  output  CHANNELS*WIDTH  registered channel words; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 frame_valid  output  1  one-cycle pulse when ch_data has just been updated.
REQ-009 slot  output  clog2(CHANNELS)  index of the slot currently being received.
REQ-010 sync_err  output  1  one-cycle pulse on an unexpected sync_in.
REQ-011 parity_err  output  CHANNELS  per-channel parity flags, valid with frame_valid.

Function
REQ-012 The block SHALL implement two states: HUNT and RECEIVE.
REQ-013 In HUNT, sync_in=0 SHALL leave all state unchanged; sync_in=1 SHALL sample data_in as slot 0 MSB, set bit count to 1 and enter RECEIVE.
REQ-014 In RECEIVE, each cycle SHALL shift data_in into the slot shift register and advance the bit counter.
REQ-015 On the last bit of a slot, the assembled word SHALL be written to that slot's staging register, the bit counter SHALL clear and slot SHALL increment.
REQ-016 On the last bit of slot CHANNELS-1, all staging words SHALL be copied to ch_data on the next rising edge, with frame_valid high for exactly that one cycle; latency is 1 clock after the last sampled bit.
REQ-017 ch_data SHALL hold its value between frame_valid pulses; partial frames SHALL never reach ch_data.
REQ-018 After the last bit of a frame the block SHALL stay in RECEIVE, treat the next bit as slot 0 MSB, and wrap slot to 0 (flywheel), whether or not sync_in is high on that bit.
REQ-019 sync_in=1 in RECEIVE on any bit other than the expected slot-0 MSB SHALL pulse sync_err for one cycle, discard the partial frame, and restart with that bit as slot 0 MSB.
REQ-020 Staging registers SHALL NOT be cleared on sync_err; stale entries are overwritten before the next transfer.
REQ-021 If a frame completes on the same cycle as an unexpected sync, the completed frame SHALL still be delivered and sync_err SHALL also pulse.
REQ-022 slot SHALL read 0 in HUNT.

Reset
REQ-023 reset SHALL asynchronously force state HUNT, counters 0, ch_data 0, staging 0, frame_valid 0, sync_err 0, parity_err 0, slot 0.
REQ-024 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait in HUNT for sync_in.

Configuration
REQ-025 Macro TDM_DEMUX_PARITY_EN defined: each slot SHALL be WIDTH+1 bits, the final bit being even parity over the slot. A mismatch SHALL set that channel's parity_err bit, registered with frame_valid. The data word SHALL still be delivered.
REQ-026 Macro undefined: slots SHALL be WIDTH bits and parity_err SHALL be constant 0.

Verification (CHANNELS=4, WIDTH=8, macro undefined unless noted)
REQ-027 sync on first bit, slots A5,3C,FF,00 MSB-first -> frame_valid one cycle after bit 32, ch_data=0x00FF3CA5, sync_err=0.
REQ-028 Two back-to-back frames, sync only on the first -> two frame_valid pulses 32 cycles apart; second ch_data reflects frame 2.
REQ-029 sync re-asserted at bit 10 of a frame -> sync_err pulse, no frame_valid at old boundary, frame_valid 32 cycles after the resync bit.
REQ-030 reset pulsed at bit 20, then a full frame 11,22,33,44 -> ch_data=0 until frame_valid, then 0x44332211.
REQ-031 TDM_DEMUX_PARITY_EN, slot 2 parity bit flipped -> frame_valid after bit 36, parity_err=4'b0100, data delivered unchanged.
